// File: rtl/dmux_stream_pkg.sv
// Shared definitions for the dmux_stream block.
// Contents:
//   sel_width() - select width for a given channel count, never below 1
//   STAT_W      - width of every statistics counter
//   STAT_MAX    - saturation value of the statistics counters
package dmux_stream_pkg;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = 16'hFFFF;

    // A two-channel block still needs one select bit.
    function automatic int sel_width(input int channels);
        return (channels > 2) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/dmux_stream_fifo.sv
// Single-clock FIFO used as the per-channel buffer of dmux_stream.
// Parameters: WIDTH (word width), DEPTH (words, power of two, >= 2)
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   push, push_data   write request and word (ignored while full)
//   pop               read request (ignored while empty)
//   full              no free slot (from registered pointers)
//   empty             no word held (registered)
//   head              oldest word, all zeros while empty (registered)
module dmux_stream_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_next;
    logic [AW:0]      rd_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;
    logic             empty_next;

    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign wr_next = wr_ptr + (AW+1)'(do_push);
    assign rd_next = rd_ptr + (AW+1)'(do_pop);
    assign empty_next = (wr_next == rd_next);

    // The head is registered, so it is computed from next-state pointers.
    // When the new head slot is the one being written this cycle, the
    // incoming word is taken directly since the memory is not yet updated.
    always_comb begin
        head_next = '0;
        if (!empty_next) begin
            if (do_push && (wr_ptr[AW-1:0] == rd_next[AW-1:0])) begin
                head_next = push_data;
            end else begin
                head_next = mem[rd_next[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            empty  <= empty_next;
            head   <= head_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/dmux_stream.sv
// Buffered N-way demultiplexer for a valid/ready word stream. Each input
// word is steered by in_sel into a per-channel FIFO; a stalled consumer
// only blocks words addressed to its own channel. Idle outputs read zero.
// Optional feature macro: DMUX_STREAM_STATS_EN (per-channel accept
// counters and a drop counter, saturating at 16'hFFFF). Without it the
// stat outputs are tied to zero; the port list is the same in both builds.
// Parameters: WIDTH, CHANNELS (2..16), DEPTH (power of two, >= 2)
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   in_data/in_sel        input word and destination channel
//   in_valid/in_ready     input handshake (in_ready independent of in_valid)
//   out_data              channel k at bits [k*WIDTH +: WIDTH]
//   out_valid/out_ready   per-channel output handshake
//   stat_sel              channel chosen for stat_count
//   stat_count            accepted words for channel stat_sel
//   stat_drop             words discarded for an out-of-range in_sel
module dmux_stream
    import dmux_stream_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 2,
    localparam int SEL_W   = sel_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    input  logic [SEL_W-1:0]          stat_sel,
    output logic [STAT_W-1:0]         stat_count,
    output logic [STAT_W-1:0]         stat_drop
);

    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [31:0]         sel_ext;

    assign sel_ext = 32'(in_sel);

    // Out-of-range selects leave in_ready at 1 so the word is swallowed.
    always_comb begin
        in_ready = 1'b1;
        push     = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (sel_ext == k) begin
                in_ready = ~full[k];
                push[k]  = in_valid & ~full[k];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        dmux_stream_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .push      (push[g]),
            .push_data (in_data),
            .pop       (pop[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .head      (out_data[g*WIDTH +: WIDTH])
        );

        assign out_valid[g] = ~empty[g];
        assign pop[g]       = ~empty[g] & out_ready[g];
    end

`ifdef DMUX_STREAM_STATS_EN
    logic [STAT_W-1:0] count_q [CHANNELS];
    logic [STAT_W-1:0] drop_q;
    logic [31:0]       stat_ext;
    logic              drop;

    assign drop     = in_valid & (sel_ext >= 32'(CHANNELS));
    assign stat_ext = 32'(stat_sel);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                count_q[k] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                if (push[k] && (count_q[k] != STAT_MAX)) begin
                    count_q[k] <= count_q[k] + STAT_W'(1);
                end
            end
            if (drop && (drop_q != STAT_MAX)) begin
                drop_q <= drop_q + STAT_W'(1);
            end
        end
    end

    always_comb begin
        stat_count = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (stat_ext == k) begin
                stat_count = count_q[k];
            end
        end
    end

    assign stat_drop = drop_q;
`else
    logic stat_sel_unused;

    assign stat_sel_unused = ^stat_sel;
    assign stat_count      = '0;
    assign stat_drop       = '0;
`endif

endmodule
